cover_toggle_drain: RTL and testbench

//  Drains a WIDTH-bit toggle-cover hit vector into one serial cover-index stream.

---
 rtl/cover_toggle_drain.sv | 112 +++++++++++
 tb/tb_cover_toggle_drain.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_drain.sv
// rtl/cover_toggle_drain.sv - round-robin drain of a toggle-cover hit vector into a serial index stream (optional rearm: COVER_TOGGLE_DRAIN_REARM_EN)
module cover_toggle_drain #(
   parameter int WIDTH       = 23,
   parameter int COVER_INDEX = 0,
   parameter int IDX_W       = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] valid,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef COVER_TOGGLE_DRAIN_REARM_EN
   input  logic             rearm,
`endif
   output logic [IDX_W-1:0] out_index,
   output logic             all_cov
);

   localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Output register states; out_valid is simply "state is FULL".
   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;

   logic             state;
   logic [WIDTH-1:0] covered;
   logic [WIDTH-1:0] pending;
   logic [PTR_W-1:0] ptr;

   logic [WIDTH-1:0] upper_pend;
   logic [PTR_W-1:0] grant;
   logic             grant_ok;
   logic             load;
   logic [WIDTH-1:0] grant_mask;
   logic [WIDTH-1:0] pending_next;
   logic [WIDTH-1:0] covered_next;
   logic [PTR_W-1:0] ptr_next;
   logic             rearm_clr;

`ifdef COVER_TOGGLE_DRAIN_REARM_EN
   assign rearm_clr = rearm;
`else
   assign rearm_clr = 1'b0;
`endif

   assign out_valid = (state == FULL);

   // Pending bits at or above the round-robin pointer get first claim on the grant.
   always_comb begin
      upper_pend = '0;
      for (int i = 0; i < WIDTH; i++) begin
         upper_pend[i] = pending[i] && (i >= int'(ptr));
      end
   end

   // Lowest upper pending bit wins; otherwise wrap to the lowest pending bit overall.
   always_comb begin
      grant = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending[i]) grant = PTR_W'(i);
      end
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (upper_pend[i]) grant = PTR_W'(i);
      end
   end

   assign grant_ok   = |pending;
   assign load       = grant_ok && ((state == EMPTY) || out_ready);
   assign grant_mask = load ? (WIDTH'(1) << grant) : '0;

   // A hit landing on the edge its point is loaded is absorbed: the grant clear overrides capture.
   assign pending_next = (pending | (valid & ~covered)) & ~grant_mask;
   // Rearm clear beats a simultaneous load so that point can be reported again.
   assign covered_next = rearm_clr ? '0 : (covered | grant_mask);
   assign ptr_next     = (int'(grant) == WIDTH - 1) ? '0 : PTR_W'(grant + 1'b1);

   // Hit capture and coverage bookkeeping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending <= '0;
         covered <= '0;
         all_cov <= 1'b0;
      end else begin
         pending <= pending_next;
         covered <= covered_next;
         all_cov <= &covered_next;
      end
   end

   // Round-robin pointer advances past each granted point.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= ptr_next;
      end
   end

   // Output register: load when empty or when the current beat is accepted, drop when drained.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= EMPTY;
         out_index <= '0;
      end else if (load) begin
         state     <= FULL;
         out_index <= IDX_W'(COVER_INDEX) + IDX_W'(grant);
      end else if ((state == FULL) && out_ready) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_cover_toggle_drain.sv
// tb/tb_cover_toggle_drain.sv - randomized self-checking bench for cover_toggle_drain against a reference model
module tb_cover_toggle_drain;

   localparam int WIDTH = 23;
   localparam int CI    = 100;
   localparam int IDX_W = 64;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] valid = '0;
   logic             out_ready = 1'b1;
   logic             out_valid;
   logic [IDX_W-1:0] out_index;
   logic             all_cov;
`ifdef COVER_TOGGLE_DRAIN_REARM_EN
   logic             rearm = 1'b0;
`endif

   cover_toggle_drain #(.WIDTH(WIDTH), .COVER_INDEX(CI), .IDX_W(IDX_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .valid     (valid),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef COVER_TOGGLE_DRAIN_REARM_EN
      .rearm     (rearm),
`endif
      .out_index (out_index),
      .all_cov   (all_cov)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // reference model: sets of reported/waiting points, a rotating search start, and the beat log
   bit     m_cov[WIDTH];
   bit     m_pend[WIDTH];
   int     m_ptr;
   bit     m_ov;
   longint m_idx;
   bit     m_all;
   int     beats[$];

   task automatic model_step();
      bit hs, free, rearm_now;
      int g;
      bit nxt[WIDTH];
      hs   = m_ov && out_ready;
      free = !m_ov || hs;
      g    = -1;
      for (int k = 0; k < WIDTH; k++)
         if (g < 0 && m_pend[(m_ptr + k) % WIDTH]) g = (m_ptr + k) % WIDTH;
      if (hs) beats.push_back(int'(m_idx));
      for (int i = 0; i < WIDTH; i++) nxt[i] = m_pend[i] || (valid[i] && !m_cov[i]);
      if (free && g >= 0) begin
         nxt[g]   = 1'b0;
         m_cov[g] = 1'b1;
         m_idx    = CI + g;
         m_ov     = 1'b1;
         m_ptr    = (g + 1) % WIDTH;
      end else if (hs) begin
         m_ov = 1'b0;
      end
      m_pend = nxt;
      rearm_now = 1'b0;
`ifdef COVER_TOGGLE_DRAIN_REARM_EN
      rearm_now = rearm;
`endif
      if (rearm_now) foreach (m_cov[i]) m_cov[i] = 1'b0;
      m_all = !rearm_now;
      foreach (m_cov[i]) if (!m_cov[i]) m_all = 1'b0;
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         foreach (m_cov[i]) begin
            m_cov[i]  = 1'b0;
            m_pend[i] = 1'b0;
         end
         m_ptr = 0;
         m_ov  = 1'b0;
         m_idx = 0;
         m_all = 1'b0;
      end else begin
         model_step();
      end
   end

   // continuous cycle-accurate comparison away from the active edge
   always @(negedge clock) begin
      if (!reset) begin
         check("out_valid", out_valid, m_ov);
         check("out_index", out_index, m_idx);
         check("all_cov", all_cov, m_all);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse(input logic [WIDTH-1:0] v);
      valid = v;
      @(negedge clock);
      valid = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      beats.delete();
   endtask

   initial begin
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] v;
      ones = '1;

      // reset state
      tick(2);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_index", out_index, 0);
      check("rst_all_cov", all_cov, 0);
      reset = 1'b0;
      beats.delete();
      tick(3);

      // 1: single hit, two-cycle latency, reported once
      pulse(WIDTH'(1));
      check("t1_lat1_valid", out_valid, 0);
      tick(1);
      check("t1_lat2_valid", out_valid, 1);
      check("t1_lat2_index", out_index, CI);
      tick(15);
      pulse(WIDTH'(1));
      tick(8);
      check("t1_beats", beats.size(), 1);
      check("t1_beat0", beats[0], CI);

`ifdef COVER_TOGGLE_DRAIN_REARM_EN
      // 6: rearm lets the point report again
      rearm = 1'b1;
      tick(1);
      rearm = 1'b0;
      pulse(WIDTH'(1));
      tick(5);
      check("t6_beats", beats.size(), 2);
      check("t6_beat1", beats[1], CI);
      pulse(WIDTH'(1));
      tick(5);
      check("t6_no_rereport", beats.size(), 2);
`endif

      // 2: all points at once, back-to-back in order
      do_reset();
      pulse(ones);
      tick(30);
      check("t2_beats", beats.size(), WIDTH);
      for (int i = 0; i < WIDTH; i++) check("t2_order", beats[i], CI + i);
      check("t2_all_cov", all_cov, 1);

      // 3: backpressure holds the beat stable
      do_reset();
      out_ready = 1'b0;
      pulse(WIDTH'(1) << 4);
      tick(1);
      for (int i = 0; i < 10; i++) begin
         check("t3_hold_valid", out_valid, 1);
         check("t3_hold_index", out_index, CI + 4);
         tick(1);
      end
      out_ready = 1'b1;
      tick(5);
      check("t3_beats", beats.size(), 1);
      check("t3_beat0", beats[0], CI + 4);

      // 4: round-robin resumes after the last granted point
      do_reset();
      pulse(WIDTH'(1) << 5);
      tick(5);
      beats.delete();
      pulse((WIDTH'(1) << 2) | (WIDTH'(1) << 7));
      tick(6);
      check("t4_beats", beats.size(), 2);
      check("t4_first", beats[0], CI + 7);
      check("t4_second", beats[1], CI + 2);

      // 5: asynchronous reset mid-stream, then restart
      do_reset();
      pulse(ones);
      tick(8);
      check("t5_pre_valid", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("t5_async_valid", out_valid, 0);
      check("t5_async_all", all_cov, 0);
      @(negedge clock);
      reset = 1'b0;
      beats.delete();
      pulse(ones);
      tick(30);
      check("t5_restart_beats", beats.size(), WIDTH);
      check("t5_restart_first", beats[0], CI);
      check("t5_all_cov", all_cov, 1);
      #2 reset = 1'b1;
      #1;
      check("t5_async_all_fall", all_cov, 0);
      check("t5_async_valid2", out_valid, 0);
      @(negedge clock);
      reset = 1'b0;
      beats.delete();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int r;
         if (i % 700 == 699) do_reset();
         r = $urandom_range(0, 9);
         if (r == 0) v = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
         else if (r < 4) v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
         else v = '0;
         valid     = v;
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef COVER_TOGGLE_DRAIN_REARM_EN
         rearm = ($urandom_range(0, 49) == 0);
`endif
         tick(1);
      end
      valid     = '0;
      out_ready = 1'b1;
`ifdef COVER_TOGGLE_DRAIN_REARM_EN
      rearm = 1'b0;
`endif
      tick(40);
      check("drain_idle", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
